// File: rtl/mult_arb_pkg.sv
// Shared types and round-robin helper for the multiplier arbiter.
// Pure declarations; no state.
// No flow control of its own.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } arb_state_t;

    // Upper bound on requester count the winner search can handle.
    localparam int RR_MAX  = 64;
    localparam int RR_IDXW = $clog2(RR_MAX);

    // Winner search starts just after `last` and wraps. The loop runs from
    // the farthest candidate inward so the nearest valid requester is
    // written last and wins. Returns `last` when nothing is requesting.
    function automatic int rr_next(
        input logic [RR_MAX-1:0] req,
        input int                last,
        input int                reqs
    );
        int idx;
        rr_next = last;
        for (int k = RR_MAX; k > 0; k--) begin
            if (k <= reqs) begin
                idx = last + k;
                if (idx >= reqs) begin
                    idx = idx - reqs;
                end
                if (req[idx[RR_IDXW-1:0]]) begin
                    rr_next = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/integer_multiplier.sv
// Combinational N-bit multiplier: low N bits of the product, top bit is the XOR of operand signs.
// Latency 0 (pure combinational).
// No flow control; output follows inputs.
module integer_multiplier #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    logic [N-1:0] full_lo;

    assign full_lo = a * b;

    // Sign comes from the operands, not the arithmetic, so 0 * negative
    // yields a "negative zero" and overflow never flips the reported sign.
    assign p = {a[N-1] ^ b[N-1], full_lo[N-2:0]};

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner select among REQS requesters, starting after last_q.
// Latency 0 (combinational).
// No flow control; caller decides whether the pick is consumed.
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int REQS = 4,
    parameter int IDW  = $clog2(REQS)
) (
    input  logic [REQS-1:0] req_valid,
    input  logic [IDW-1:0]  last_q,
    output logic [REQS-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_req
);

    logic [RR_MAX-1:0] req_pad;

    always_comb begin
        req_pad               = '0;
        req_pad[REQS-1:0]     = req_valid;
        any_req               = |req_valid;
        grant_idx             = IDW'(rr_next(req_pad, int'(last_q), REQS));
        grant_onehot          = '0;
        grant_onehot[grant_idx] = any_req;
    end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Shares one integer_multiplier between REQS requesters with round-robin grant and a tagged response.
// Latency: grant in cycle T, rsp_valid in T+2; one result per 2 cycles at full rate.
// Backpressure: rsp_ready low holds DONE and keeps every req_ready low until the response drains.
module mult_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N    = 32,
    parameter int REQS = 4,
    parameter int IDW  = $clog2(REQS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REQS-1:0]        req_valid,
    output logic [REQS-1:0]        req_ready,
    input  logic [REQS-1:0][N-1:0] req_a,
    input  logic [REQS-1:0][N-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [N-1:0]           rsp_product
);

    arb_state_t       state_q;
    logic [IDW-1:0]   last_q;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [IDW-1:0]   op_id;
    logic [N-1:0]     res_q;
    logic [N-1:0]     mul_p;

    logic [REQS-1:0]  grant_onehot;
    logic [IDW-1:0]   grant_idx;
    logic             any_req;
    logic             accept_slot;
    logic             grant_fire;

    rr_pick #(
        .REQS (REQS),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid    (req_valid),
        .last_q       (last_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any_req      (any_req)
    );

    integer_multiplier #(
        .N (N)
    ) u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    // A new operation may enter when idle, or in the same cycle the held
    // response is consumed. Reset masks the grant so req_ready is 0 while
    // rst_n is low regardless of req_valid.
    always_comb begin
        accept_slot = (state_q == IDLE) || ((state_q == DONE) && rsp_ready);
        grant_fire  = rst_n && any_req && accept_slot;
        req_ready   = grant_fire ? grant_onehot : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(REQS - 1);
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            res_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        op_a    <= req_a[grant_idx];
                        op_b    <= req_b[grant_idx];
                        op_id   <= grant_idx;
                        last_q  <= grant_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q     <= mul_p;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (grant_fire) begin
                            op_a    <= req_a[grant_idx];
                            op_b    <= req_b[grant_idx];
                            op_id   <= grant_idx;
                            last_q  <= grant_idx;
                            state_q <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_product = res_q;

    a_req_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter with hand-computed expected values.
module tb_mult_rr_arbiter;

    localparam int N    = 32;
    localparam int REQS = 4;
    localparam int IDW  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [REQS-1:0]        req_valid;
    logic [REQS-1:0]        req_ready;
    logic [REQS-1:0][N-1:0] req_a;
    logic [REQS-1:0][N-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [N-1:0]           rsp_product;

    int n_checks = 0;
    int n_errors = 0;
    int exp_idx;
    int prev_idx;

    always #5 clk = ~clk;

    mult_rr_arbiter #(
        .N    (N),
        .REQS (REQS),
        .IDW  (IDW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [REQS-1:0] oh(input int i);
        oh = '0;
        oh[i[1:0]] = 1'b1;
    endfunction

    function automatic logic [N-1:0] rr_prod(input int i);
        rr_prod = N'((i + 2) * (100 + i));
    endfunction

    // Entered at a negedge with the DUT idle; leaves it idle at a negedge.
    task automatic run_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_p);
        req_valid      = oh(idx);
        req_a[idx]     = a;
        req_b[idx]     = b;
        rsp_ready      = 1'b1;
        #1 check("op_grant", 64'(req_ready), 64'(oh(idx)));
        @(posedge clk);
        @(negedge clk);
        req_valid  = '0;
        req_a[idx] = ~a;
        req_b[idx] = b + 32'd1;
        check("op_exec_quiet", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("op_rsp_valid", 64'(rsp_valid), 64'd1);
        check("op_rsp_id", 64'(rsp_id), 64'(idx));
        check("op_rsp_product", 64'(rsp_product), 64'(exp_p));
        @(posedge clk);
        @(negedge clk);
        check("op_back_idle", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_product", 64'(rsp_product), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First op after reset: 3*5 from requester 0, consumer stalled.
        req_valid = 4'b0001;
        req_a[0]  = 32'd3;
        req_b[0]  = 32'd5;
        #1 check("t1_grant", 64'(req_ready), 64'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        req_a[0]  = 32'd99;
        check("t1_exec_quiet", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_rsp_id", 64'(rsp_id), 64'd0);
        check("t1_rsp_product", 64'(rsp_product), 64'd15);

        // Stall in DONE with requester 2 waiting (-2 * 3).
        req_valid = 4'b0100;
        req_a[2]  = 32'hFFFF_FFFE;
        req_b[2]  = 32'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall_rsp_id", 64'(rsp_id), 64'd0);
            check("stall_rsp_product", 64'(rsp_product), 64'd15);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 check("b2b_grant_req2", 64'(req_ready), 64'h4);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = '0;
        check("b2b_exec_quiet", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("neg_rsp_valid", 64'(rsp_valid), 64'd1);
        check("neg_rsp_id", 64'(rsp_id), 64'd2);
        check("neg_rsp_product", 64'(rsp_product), 64'hFFFF_FFFA);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("neg_back_idle", 64'(rsp_valid), 64'd0);

        run_op(1, 32'd0, 32'hFFFF_FFFB, 32'h8000_0000);
        run_op(3, 32'd7, 32'd0, 32'h0000_0000);
        run_op(2, 32'h0001_0001, 32'h0001_0000, 32'h0001_0000);
        run_op(0, 32'd11, 32'd13, 32'd143);

        // All four requesting, consumer always ready; pointer last granted 0.
        for (int i = 0; i < REQS; i++) begin
            req_a[i] = N'(i + 2);
            req_b[i] = N'(100 + i);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        exp_idx   = 1;
        prev_idx  = 0;
        for (int g = 0; g < 8; g++) begin
            #1;
            check("rr_grant", 64'(req_ready), 64'(oh(exp_idx)));
            if (g > 0) begin
                check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
                check("rr_rsp_id", 64'(rsp_id), 64'(prev_idx));
                check("rr_rsp_product", 64'(rsp_product), 64'(rr_prod(prev_idx)));
            end
            @(posedge clk);
            @(negedge clk);
            check("rr_exec_no_grant", 64'(req_ready), 64'd0);
            check("rr_exec_quiet", 64'(rsp_valid), 64'd0);
            @(negedge clk);
            prev_idx = exp_idx;
            exp_idx  = (exp_idx + 1) % REQS;
        end
        req_valid = '0;
        #1;
        check("rr_last_rsp_id", 64'(rsp_id), 64'(prev_idx));
        check("rr_last_rsp_product", 64'(rsp_product), 64'(rr_prod(prev_idx)));
        @(posedge clk);
        @(negedge clk);

        // Reset while the requester-2 operation is in EXEC.
        req_valid = 4'b0100;
        #1 check("rst_mid_grant", 64'(req_ready), 64'h4);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_old_product", 64'(rsp_product), 64'(rr_prod(0)));
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_rsp_product", 64'(rsp_product), 64'd0);
        check("rst_mid_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_ghost_rsp", 64'(rsp_valid), 64'd0);
        end
        req_valid = 4'b1111;
        #1 check("rst_ptr_grant0", 64'(req_ready), 64'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("rst_after_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rst_after_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_after_rsp_product", 64'(rsp_product), 64'(rr_prod(0)));
        @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_rr_arbiter.md
# mult_rr_arbiter

Shares one `integer_multiplier` datapath between `REQS` independent requesters using a round-robin arbiter and per-requester valid/ready handshakes. Each requester presents an operand pair. The block grants one requester, registers the operands, and registers the multiplier result. It then returns the product on a single tagged response channel. It sits between the integer-pipeline issue logic and the shared multiplier, so one multiplier instance serves several lanes.

## Interface
Parameters:
- `N`, 32, operand and product width in bits.
- `REQS`, 4, number of requesters (≥2).
- `IDW`, `$clog2(REQS)`, width of the requester tag.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  REQS  per-requester request.
- `req_ready`  out  REQS  per-requester accept (one-hot or zero).
- `req_a`  in  REQS×N  per-requester multiplicand.
- `req_b`  in  REQS×N  per-requester multiplier.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_product`  out  N  product, bit-exact `integer_multiplier` output.

## Operation
- FSM states:
  - IDLE: no operation held.
  - EXEC: operands registered, multiplier evaluating.
  - DONE: result held, `rsp_valid`=1.
- IDLE: if any `req_valid`, grant the winner. Assert `req_ready[winner]`, capture `req_a`/`req_b`/id into `op_a`/`op_b`/`op_id`, then go to EXEC. Otherwise stay in IDLE.
- EXEC: always lasts one cycle. Register the multiplier output into `res_q`, then go to DONE.
- DONE: hold `rsp_valid`, `rsp_id`, `rsp_product` stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready` with a pending request: accept the next request in the same cycle, as in IDLE, and go to EXEC (back-to-back).
  - On `rsp_valid && rsp_ready` with no pending request: go to IDLE.
- `req_ready` is asserted only in IDLE, or in DONE && `rsp_ready`. It is combinational from `req_valid`, state, pointer and `rsp_ready`.
- Round robin:
  - Pointer `last_q` holds the last granted index.
  - Search order is `last_q+1` … `last_q+REQS`, mod REQS.
  - The first requester with `req_valid` set wins.
  - `last_q` updates only on an actual grant.
- Operands are sampled only at grant. Later changes to `req_*`, or deassertion of `req_valid`, do not affect the in-flight operation.
- A requester may hold `req_valid` indefinitely. Fairness guarantee: it is granted within REQS grants.
- Arithmetic: operands are passed unmodified to `integer_multiplier`, and `rsp_product` is its output without correction. This includes the sign bit being the XOR of the operand signs even when the product is zero. Overflow is truncated silently.

## Timing
- Reset values:
  - state=IDLE
  - `last_q`=REQS-1, so requester 0 wins first after reset
  - `rsp_valid`=0
  - `rsp_id`=0
  - `rsp_product`=0
  - `req_ready`=0
- Reset mid-operation: the in-flight operation is discarded and no response is produced. The round-robin pointer returns to its reset value.
- Latency: grant in cycle T → `rsp_valid` in cycle T+2.
- Throughput: one result per 2 cycles with `rsp_ready` held high (DONE→EXEC→DONE).
- `rsp_ready` while `rsp_valid`=0 is ignored.
- No combinational path from `req_*` to `rsp_*`.

## Structure
- Package `mult_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, EXEC, DONE} arb_state_t`
  - the `rr_next` winner function
- Sub-module `rr_pick` (combinational, parameter REQS):
  - inputs: `req_valid`, `last_q`
  - outputs: `grant_onehot`, `grant_idx`, `any_req`
- One `integer_multiplier #(N)` instance, fed from `op_a`/`op_b`.

## Test plan
- Reset, then `req_valid`=4'b0001 with a=3, b=5:
  - `req_ready[0]` in the grant cycle.
  - `rsp_valid` 2 cycles later with id=0, product=32'd15.
- All four requesters valid continuously, `rsp_ready`=1:
  - grants follow 0,1,2,3,0,…
  - one response every 2 cycles
  - ids match grant order
- Hold `rsp_ready`=0 for 5 cycles in DONE:
  - `rsp_*` stay stable and `req_ready`=0 throughout.
  - Raising `rsp_ready` with req2 pending grants req2 in the same cycle.
- Operand sign and zero cases:
  - a=-2, b=3 → 32'hFFFF_FFFA
  - a=0, b=-5 → 32'h8000_0000
  - a=7, b=0 → 32'h0000_0000
- Change `req_a` and drop `req_valid` one cycle after grant: the product reflects the originally sampled operands.
- Assert `rst_n`=0 during EXEC:
  - outputs return to reset values immediately, and no response appears after release.
  - The next grant goes to requester 0.
